// File: rtl/ibuf_feed.sv
// Input-side sample feeder: bus-loaded data/mask buffers streamed to the systolic array.
// Latency: first sw 2 cycles after start; finish one cycle after the last sw. hold stalls sw with s_in/s_en frozen.
// Optional IBUF_READBACK_EN adds a 1-cycle-latency bus read-back port on both buffers.
module ibuf_feed #(
    parameter int AW = 7,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [8:0]    ibus_wadr,
    input  logic [15:0]   ibus_wdata,
    input  logic          ibus_wen,
    input  logic [8:0]    ibus_radr,
    output logic [15:0]   ibus_rdata,
    input  logic [7:0]    run_cntr,
    input  logic          start,
    input  logic          hold,
    output logic [DW-1:0] s_in,
    output logic          s_en,
    output logic          sw,
    output logic          s_running,
    output logic          finish
);

    typedef enum logic [1:0] {IDLE, FETCH, RUN, DONE} state_t;

    state_t        state;
    logic [7:0]    rem;
    logic [7:0]    idx;

    logic [DW-1:0] data_mem [2**AW];
    logic [15:0]   mask_mem [2**AW];

    logic [DW-1:0] data_q;
    logic [15:0]   mask_q;
    logic [3:0]    bit_q;

    logic          data_we;
    logic          mask_we;
    logic          rd_en;
    logic [7:0]    rd_idx;

    assign data_we = ibus_wen & ~ibus_wadr[8];
    assign mask_we = ibus_wen &  ibus_wadr[8];

    assign sw = (state == RUN) & ~hold;

    // Read ahead: FETCH primes sample 0, each strobe fetches the following sample.
    // With no read, the RAM output registers keep s_in/s_en stable across holds.
    assign rd_en  = (state == FETCH) | sw;
    assign rd_idx = (state == FETCH) ? 8'd0 : idx + 8'd1;

    always_ff @(posedge clk) begin
        if (data_we)
            data_mem[ibus_wadr[AW-1:0]] <= DW'(ibus_wdata);
        if (mask_we)
            mask_mem[ibus_wadr[AW-1:0]] <= ibus_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            mask_q <= '0;
            bit_q  <= '0;
        end else if (rd_en) begin
            data_q <= data_mem[rd_idx[AW-1:0]];
            mask_q <= mask_mem[AW'(rd_idx[7:4])];
            bit_q  <= 4'd15 - rd_idx[3:0];
        end
    end

    assign s_in = data_q;
    assign s_en = mask_q[bit_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem       <= '0;
            idx       <= '0;
            s_running <= 1'b0;
            finish    <= 1'b0;
        end else begin
            finish <= 1'b0;
            if (start) begin
                rem <= run_cntr;
                idx <= '0;
                if (run_cntr != 8'd0) begin
                    state     <= FETCH;
                    s_running <= 1'b1;
                end else begin
                    state     <= DONE;
                    s_running <= 1'b0;
                    finish    <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        s_running <= 1'b0;
                    end
                    FETCH: begin
                        state     <= RUN;
                        s_running <= 1'b1;
                    end
                    RUN: begin
                        if (!hold) begin
                            idx <= idx + 8'd1;
                            rem <= rem - 8'd1;
                            if (rem == 8'd1) begin
                                state     <= DONE;
                                s_running <= 1'b0;
                                finish    <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state     <= IDLE;
                        s_running <= 1'b0;
                    end
                    default: begin
                        state     <= IDLE;
                        s_running <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef IBUF_READBACK_EN
    logic          rb_sel;
    logic [DW-1:0] rb_data;
    logic [15:0]   rb_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_sel  <= 1'b0;
            rb_data <= '0;
            rb_mask <= '0;
        end else begin
            rb_sel  <= ibus_radr[8];
            rb_data <= data_mem[ibus_radr[AW-1:0]];
            rb_mask <= mask_mem[ibus_radr[AW-1:0]];
        end
    end

    assign ibus_rdata = rb_sel ? rb_mask : 16'(rb_data);

    wire unused_radr = ibus_radr[7];
`else
    assign ibus_rdata = '0;

    wire unused_radr = ^ibus_radr;
`endif

    wire unused_wadr = ibus_wadr[7];

endmodule

// File: tb/tb_ibuf_feed.sv
// Directed + randomized bench for ibuf_feed against a sample-sequence reference model.
module tb_ibuf_feed;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  ibus_wadr;
    logic [15:0] ibus_wdata;
    logic        ibus_wen;
    logic [8:0]  ibus_radr;
    logic [15:0] ibus_rdata;
    logic [7:0]  run_cntr;
    logic        start;
    logic        hold;
    logic [15:0] s_in;
    logic        s_en;
    logic        sw;
    logic        s_running;
    logic        finish;

    int tests = 0;
    int fails = 0;

    logic [15:0] dm [128];
    logic [15:0] mm [128];

    ibuf_feed #(.AW(7), .DW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ibus_wadr  (ibus_wadr),
        .ibus_wdata (ibus_wdata),
        .ibus_wen   (ibus_wen),
        .ibus_radr  (ibus_radr),
        .ibus_rdata (ibus_rdata),
        .run_cntr   (run_cntr),
        .start      (start),
        .hold       (hold),
        .s_in       (s_in),
        .s_en       (s_en),
        .sw         (sw),
        .s_running  (s_running),
        .finish     (finish)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [8:0] a, input logic [15:0] d);
        ibus_wadr  = a;
        ibus_wdata = d;
        ibus_wen   = 1'b1;
        if (a[8]) mm[a[6:0]] = d;
        else      dm[a[6:0]] = d;
        tick();
        ibus_wen = 1'b0;
    endtask

    // mode: 0 no hold, 1 random hold, 2 hold for 3 cycles on sample 1.
    // Returns cycle (counted from start) at which finish was seen, -1 if aborted/timed out.
    task automatic run(input int n, input int mode, input int abort_after, output int fin_cyc);
        int          k;
        int          hc;
        bit          done;
        bit          aborted;
        logic [15:0] w;
        run_cntr = 8'(n);
        start    = 1'b1;
        hold     = 1'b1;
        tick();
        start   = 1'b0;
        k       = 0;
        hc      = 0;
        done    = 1'b0;
        aborted = 1'b0;
        fin_cyc = -1;
        for (int c = 1; c < 3000 && !done; c++) begin
            case (mode)
                1:       hold = ($urandom_range(0, 3) == 0);
                2:       hold = (k == 1 && hc < 3);
                default: hold = 1'b0;
            endcase
            if (mode == 2 && k == 1 && hold) hc++;
            @(negedge clk);
            if (c == 1 && n != 0) begin
                chk("fetch_running", s_running, 1);
                chk("fetch_sw", sw, 0);
                chk("fetch_finish", finish, 0);
            end else if (k < n) begin
                w = mm[k >> 4];
                chk("run_running", s_running, 1);
                chk("run_finish", finish, 0);
                chk("run_sw", sw, !hold);
                chk("run_s_in", s_in, dm[k % 128]);
                chk("run_s_en", s_en, w[15 - (k % 16)]);
                if (!hold) k++;
                if (abort_after > 0 && k == abort_after) begin
                    done    = 1'b1;
                    aborted = 1'b1;
                end
            end else begin
                chk("done_finish", finish, 1);
                chk("done_running", s_running, 0);
                chk("done_sw", sw, 0);
                fin_cyc = c;
                done    = 1'b1;
            end
            tick();
        end
        hold = 1'b0;
        if (!done) chk("run_timeout", 0, 1);
        if (done && !aborted) begin
            @(negedge clk);
            chk("post_finish", finish, 0);
            chk("post_running", s_running, 0);
            tick();
        end
    endtask

    initial begin
        int fin;
        int n;
        rst_n      = 1'b0;
        ibus_wadr  = '0;
        ibus_wdata = '0;
        ibus_wen   = 1'b0;
        ibus_radr  = '0;
        run_cntr   = '0;
        start      = 1'b0;
        hold       = 1'b0;

        #22;
        chk("rst_s_in", s_in, 0);
        chk("rst_s_en", s_en, 0);
        chk("rst_sw", sw, 0);
        chk("rst_running", s_running, 0);
        chk("rst_finish", finish, 0);
        chk("rst_rdata", ibus_rdata, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 128; i++) wr(9'(i), 16'($urandom));
        for (int i = 0; i < 16; i++) wr(9'h100 | 9'(i), 16'($urandom));

        // Basic 4-sample run
        wr(9'h000, 16'h1111);
        wr(9'h001, 16'h2222);
        wr(9'h002, 16'h3333);
        wr(9'h003, 16'h4444);
        wr(9'h100, 16'hA000);
        run(4, 0, 0, fin);
        chk("t1_fin_cycle", fin, 6);

        run(4, 2, 0, fin);
        chk("t2_fin_cycle", fin, 9);

        run(0, 0, 0, fin);
        chk("t3_fin_cycle", fin, 1);

        wr(9'h100, 16'hFFFF);
        wr(9'h101, 16'h8000);
        run(20, 0, 0, fin);
        chk("t4_fin_cycle", fin, 22);

        run(10, 0, 2, fin);
        run(10, 0, 0, fin);
        chk("t5_fin_cycle", fin, 12);

`ifdef IBUF_READBACK_EN
        wr(9'h105, 16'hBEEF);
        ibus_radr = 9'h105;
        tick();
        @(negedge clk);
        chk("rb_mask", ibus_rdata, 16'hBEEF);
        ibus_radr = 9'h003;
        tick();
        @(negedge clk);
        chk("rb_data", ibus_rdata, 16'h4444);
`else
        ibus_radr = 9'h105;
        tick();
        @(negedge clk);
        chk("rb_off", ibus_rdata, 0);
        tick();
`endif

        for (int i = 0; i < 128; i++) wr(9'(i), 16'($urandom));
        for (int i = 0; i < 16; i++) wr(9'h100 | 9'(i), 16'($urandom));
        run(200, 0, 0, fin);
        chk("wrap_fin_cycle", fin, 202);
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 255);
            run(n, 1, 0, fin);
            chk("rand_fin_seen", (fin > n + 1) ? 1 : 0, 1);
        end

        // Asynchronous reset in the middle of a run
        run_cntr = 8'd50;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_running", s_running, 0);
        chk("arst_sw", sw, 0);
        chk("arst_finish", finish, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("arst_no_finish", finish, 0);
            chk("arst_idle", s_running, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
